// File: rtl/wifi_pkg.sv
// wifi_pkg: shared FSM encoding, register addresses and status bit positions for the WiFi reset sequencer
package wifi_pkg;

   typedef enum logic [1:0] {
      ASSERT = 2'd0,
      BOOT   = 2'd1,
      RUN    = 2'd2
   } state_t;

   localparam logic [1:0] ADDR_STATUS = 2'd0;
   localparam logic [1:0] ADDR_PULSE  = 2'd1;

   localparam int ST_READY = 0;
   localparam int ST_RST_N = 1;
   localparam int ST_STATE = 2;
   localparam int ST_REQ   = 4;

endpackage

// File: rtl/wifi_reset_sequencer_sync2.sv
// sync2: two-flop synchronizer with a selectable reset value
module sync2 #(
   parameter logic RST_VAL = 1'b1
) (
   input  logic clk,
   input  logic reset_n,
   input  logic d,
   output logic q
);

   logic meta;

   // shift the async input through two flops to settle metastability
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) {q, meta} <= {2{RST_VAL}};
      else          {q, meta} <= {meta, d};

endmodule

// File: rtl/wifi_reset_sequencer.sv
// wifi_reset_sequencer: stretches PIO reset requests into a WiFi reset pulse, times the boot window, exposes status over Avalon-MM
module wifi_reset_sequencer
   import wifi_pkg::*;
#(
   parameter int ASSERT_CYCLES = 50000,
   parameter int BOOT_CYCLES   = 25000000,
   parameter int CNT_W         = 25
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        rst_req_n,
   input  logic [1:0]  address,
   input  logic        chipselect,
   input  logic        write_n,
   input  logic [31:0] writedata,
   output logic [31:0] readdata,
   output logic        wifi_rst_n,
   output logic        wifi_ready
);

   localparam logic [CNT_W-1:0] A_LOAD = CNT_W'(ASSERT_CYCLES - 1);
   localparam logic [CNT_W-1:0] B_LOAD = CNT_W'(BOOT_CYCLES - 1);

   state_t           state, state_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic             req_s, req_prev, pend, inc, clr;
   logic [7:0]       pulse_cnt;
   logic             unused_wdata;

   assign unused_wdata = ^writedata;
   assign clr = chipselect && !write_n && address == ADDR_PULSE;

   sync2 #(.RST_VAL(1'b1)) u_sync (
      .clk     (clk),
      .reset_n (reset_n),
      .d       (rst_req_n),
      .q       (req_s)
   );

   // next state and shared down-counter; a request in BOOT or RUN always restarts the full pulse
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      inc       = 1'b0;
      case (state)
         ASSERT: begin
            state_nxt = (cnt == '0 && req_s) ? BOOT : ASSERT;
            cnt_nxt   = cnt != '0 ? cnt - 1'b1 : req_s ? B_LOAD : '0;
         end
         BOOT, RUN: begin
            inc       = pend || !req_s;
            state_nxt = inc ? ASSERT : (state == BOOT && cnt == '0) ? RUN : state;
            cnt_nxt   = inc ? A_LOAD : state == BOOT ? cnt - 1'b1 : cnt;
         end
         default: begin
            state_nxt = ASSERT;
            cnt_nxt   = A_LOAD;
         end
      endcase
   end

   // state, counter, edge latch, pulse counter and pins registered from the next state
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
         state      <= ASSERT;
         cnt        <= A_LOAD;
         pend       <= 1'b0;
         req_prev   <= 1'b1;
         pulse_cnt  <= '0;
         wifi_rst_n <= 1'b0;
         wifi_ready <= 1'b0;
      end else begin
         state      <= state_nxt;
         cnt        <= cnt_nxt;
         req_prev   <= req_s;
         pend       <= state_nxt != state ? 1'b0 : pend | (req_prev & ~req_s);
         pulse_cnt  <= clr ? '0 : (inc && pulse_cnt != 8'hFF) ? pulse_cnt + 8'd1 : pulse_cnt;
         wifi_rst_n <= state_nxt != ASSERT;
         wifi_ready <= state_nxt == RUN;
      end

   // zero-latency read mux
   always_comb begin
      readdata = '0;
      if (address == ADDR_STATUS) begin
         readdata[ST_READY]       = wifi_ready;
         readdata[ST_RST_N]       = wifi_rst_n;
         readdata[ST_STATE +: 2]  = state;
         readdata[ST_REQ]         = req_s;
      end else if (address == ADDR_PULSE)
         readdata[7:0] = pulse_cnt;
   end

endmodule

// File: tb/tb_wifi_reset_sequencer.sv
// tb_wifi_reset_sequencer: directed stimulus with a cycle-stamped scoreboard for the WiFi reset sequencer
module tb_wifi_reset_sequencer;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        rst_req_n = 1'b1;
   logic [1:0]  address = 2'd0;
   logic        chipselect = 1'b0;
   logic        write_n = 1'b1;
   logic [31:0] writedata = '0;
   logic [31:0] readdata;
   logic        wifi_rst_n, wifi_ready;

   typedef struct {
      int          at;
      bit          is_rd;
      logic [31:0] exp;
      string       name;
   } exp_t;

   exp_t q[$];
   int   cyc = 0;
   int   n_chk = 0;
   int   n_pass = 0;

   wifi_reset_sequencer #(.ASSERT_CYCLES(4), .BOOT_CYCLES(8), .CNT_W(25)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .rst_req_n  (rst_req_n),
      .address    (address),
      .chipselect (chipselect),
      .write_n    (write_n),
      .writedata  (writedata),
      .readdata   (readdata),
      .wifi_rst_n (wifi_rst_n),
      .wifi_ready (wifi_ready)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // monitor: at each falling edge, retire every expectation stamped for this cycle
   always @(negedge clk) begin
      exp_t e;
      logic [31:0] act;
      while (q.size() > 0 && q[0].at <= cyc) begin
         e = q.pop_front();
         act = e.is_rd ? readdata : {30'b0, wifi_rst_n, wifi_ready};
         n_chk++;
         if (e.at != cyc)
            $display("FAIL %s: expectation for cycle %0d missed (now %0d)", e.name, e.at, cyc);
         else if (act !== e.exp)
            $display("FAIL %s @cycle %0d: got 0x%08h, expected 0x%08h", e.name, cyc, act, e.exp);
         else
            n_pass++;
      end
   end

   task automatic push(input int at, input bit is_rd, input logic [31:0] v, input string name);
      exp_t e;
      int i;
      e.at = at; e.is_rd = is_rd; e.exp = v; e.name = name;
      i = 0;
      while (i < q.size() && q[i].at <= at) i++;
      q.insert(i, e);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_until(input int c);
      while (cyc < c) tick();
   endtask

   // expected pins {wifi_rst_n, wifi_ready} after every edge from a to b
   task automatic pins(input int a, input int b, input logic rst_n, input logic rdy, input string name);
      for (int c = a; c <= b; c++) push(c, 1'b0, {30'b0, rst_n, rdy}, name);
   endtask

   task automatic rd(input logic [1:0] a, input logic [31:0] v, input string name);
      address = a;
      push(cyc, 1'b1, v, name);
      tick();
   endtask

   task automatic wr(input logic [1:0] a, input logic [31:0] d);
      chipselect = 1'b1; write_n = 1'b0; address = a; writedata = d;
      tick();
      chipselect = 1'b0; write_n = 1'b1;
   endtask

   task automatic por();
      int c0;
      c0 = cyc;
      pins(c0, c0 + 3, 1'b0, 1'b0, "por_assert");
      pins(c0 + 4, c0 + 11, 1'b1, 1'b0, "por_boot");
      pins(c0 + 12, c0 + 13, 1'b1, 1'b1, "por_ready");
      reset_n = 1'b1;
      wait_until(c0 + 14);
      rd(2'd1, 32'h0, "por_pulse_cnt");
      rd(2'd0, 32'h1B, "status_run");
   endtask

   task automatic glitch(input logic [31:0] n_exp);
      int g;
      g = cyc;
      pins(g + 1, g + 2, 1'b1, 1'b1, "glitch_run");
      pins(g + 3, g + 6, 1'b0, 1'b0, "glitch_assert");
      pins(g + 7, g + 14, 1'b1, 1'b0, "glitch_boot");
      pins(g + 15, g + 16, 1'b1, 1'b1, "glitch_ready");
      rst_req_n = 1'b0;
      tick();
      rst_req_n = 1'b1;
      wait_until(g + 2);
      rd(2'd0, 32'h0B, "status_req_low");
      wait_until(g + 4);
      rd(2'd0, 32'h10, "status_assert");
      wait_until(g + 16);
      rd(2'd1, n_exp, "glitch_pulse_cnt");
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: stimulus did not complete");
      $fatal(1);
   end

   initial begin
      int h, b, g, r;
      tick(); tick();
      pins(cyc, cyc, 1'b0, 1'b0, "reset_pins");
      rd(2'd0, 32'h10, "reset_status");
      rd(2'd1, 32'h0, "reset_pulse_cnt");
      por();
      glitch(32'd1);
      h = cyc;
      pins(h + 1, h + 2, 1'b1, 1'b1, "held_run");
      pins(h + 3, h + 22, 1'b0, 1'b0, "held_assert");
      pins(h + 23, h + 30, 1'b1, 1'b0, "held_boot");
      pins(h + 31, h + 32, 1'b1, 1'b1, "held_ready");
      rst_req_n = 1'b0;
      repeat (20) tick();
      rst_req_n = 1'b1;
      wait_until(h + 33);
      rd(2'd1, 32'd2, "held_pulse_cnt");
      b = cyc;
      pins(b + 3, b + 6, 1'b0, 1'b0, "breq_assert1");
      pins(b + 7, b + 13, 1'b1, 1'b0, "breq_boot1");
      pins(b + 14, b + 17, 1'b0, 1'b0, "breq_assert2");
      pins(b + 18, b + 25, 1'b1, 1'b0, "breq_boot2");
      pins(b + 26, b + 27, 1'b1, 1'b1, "breq_ready");
      rst_req_n = 1'b0;
      tick();
      rst_req_n = 1'b1;
      wait_until(b + 11);
      rst_req_n = 1'b0;
      tick();
      rst_req_n = 1'b1;
      wait_until(b + 28);
      rd(2'd1, 32'd4, "breq_pulse_cnt");
      for (int i = 0; i < 300; i++) begin
         rst_req_n = 1'b0;
         tick();
         rst_req_n = 1'b1;
         repeat (16) tick();
      end
      rd(2'd1, 32'd255, "pulse_cnt_saturated");
      wr(2'd0, 32'hFFFF_FFFF);
      wr(2'd2, 32'hFFFF_FFFF);
      wr(2'd3, 32'hFFFF_FFFF);
      rd(2'd1, 32'd255, "ignored_writes");
      rd(2'd0, 32'h1B, "status_after_writes");
      rd(2'd2, 32'h0, "addr2_zero");
      rd(2'd3, 32'h0, "addr3_zero");
      wr(2'd1, 32'h0);
      rd(2'd1, 32'd0, "pulse_cnt_cleared");
      glitch(32'd1);
      g = cyc;
      pins(g + 3, g + 6, 1'b0, 1'b0, "collide_assert");
      rst_req_n = 1'b0;
      tick();
      rst_req_n = 1'b1;
      tick();
      wr(2'd1, 32'h0);
      wait_until(g + 16);
      rd(2'd1, 32'd0, "clear_beats_increment");
      r = cyc;
      pins(r + 3, r + 6, 1'b0, 1'b0, "pre_reset_assert");
      pins(r + 7, r + 8, 1'b1, 1'b0, "pre_reset_boot");
      rst_req_n = 1'b0;
      tick();
      rst_req_n = 1'b1;
      wait_until(r + 9);
      reset_n = 1'b0;
      pins(cyc, cyc, 1'b0, 1'b0, "async_reset_pins");
      rd(2'd1, 32'd0, "async_reset_pulse_cnt");
      rd(2'd0, 32'h10, "async_reset_status");
      por();
      repeat (3) tick();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
